// File: rtl/cpu.sv
// cpu: multi-cycle RV32I core with a fetch/exec/mem FSM and a 16-bit word bus.
// Ports: clk, rst (sync, active-high), rd_en/rd_addr/rd_data/rd_valid, wr_en/wr_addr/wr_data.
// Macro CPU_TRACE_EN: when defined, one $display per instruction in EXEC.
module cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   input  logic [31:0] rd_data,
   input  logic        rd_valid,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [31:0] wr_data
);
   typedef enum logic [2:0] {
      FETCH, FWAIT, EXEC, LOAD, LWAIT, STORE
   } state_t;

   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL   = 7'h6f;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_BR    = 7'h63;
   localparam logic [6:0] OP_LD    = 7'h03;
   localparam logic [6:0] OP_ST    = 7'h23;
   localparam logic [6:0] OP_IMM   = 7'h13;
   localparam logic [6:0] OP_REG   = 7'h33;

   state_t      state, state_n;
   logic [31:0] pc, pc_n, ir;
   logic [31:0] regs [32];
   logic        we;
   logic [31:0] wb;

   logic [6:0]  opc;
   logic [4:0]  rd_i, rs1_i, rs2_i;
   logic [2:0]  f3;
   logic [31:0] rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opc   = ir[6:0];
   assign rd_i  = ir[11:7];
   assign f3    = ir[14:12];
   assign rs1_i = ir[19:15];
   assign rs2_i = ir[24:20];
   assign rs1   = (rs1_i == 5'd0) ? 32'd0 : regs[rs1_i];
   assign rs2   = (rs2_i == 5'd0) ? 32'd0 : regs[rs2_i];

   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u = {ir[31:12], 12'd0};
   assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   // Only the low 16 address bits reach the bus
   logic [15:0] ea, ea_w;
   assign ea   = rs1[15:0] + ((opc == OP_ST) ? imm_s[15:0] : imm_i[15:0]);
   assign ea_w = {ea[15:2], 2'b00};

   logic [31:0]        op_b, alu;
   logic signed [31:0] sra_v;
   logic               alt;

   // ir[30] selects SUB/SRA only for OP, and SRAI for OP-IMM
   always_comb begin
      op_b  = (opc == OP_REG) ? rs2 : imm_i;
      alt   = ir[30] && ((opc == OP_REG) || (f3 == 3'b101));
      sra_v = $signed(rs1) >>> op_b[4:0];
      alu   = 32'd0;
      case (f3)
         3'b000: alu = alt ? rs1 - op_b : rs1 + op_b;
         3'b001: alu = rs1 << op_b[4:0];
         3'b010: alu = {31'd0, $signed(rs1) < $signed(op_b)};
         3'b011: alu = {31'd0, rs1 < op_b};
         3'b100: alu = rs1 ^ op_b;
         3'b101: alu = alt ? sra_v : rs1 >> op_b[4:0];
         3'b110: alu = rs1 | op_b;
         default: alu = rs1 & op_b;
      endcase
   end

   logic take;

   always_comb begin
      take = 1'b0;
      case (f3)
         3'b000: take = rs1 == rs2;
         3'b001: take = rs1 != rs2;
         3'b100: take = $signed(rs1) < $signed(rs2);
         3'b101: take = $signed(rs1) >= $signed(rs2);
         3'b110: take = rs1 < rs2;
         3'b111: take = rs1 >= rs2;
         default: take = 1'b0;
      endcase
   end

   logic [7:0]  lb;
   logic [15:0] lh;
   logic [31:0] ldv;

   always_comb begin
      lb = rd_data[7:0];
      case (ea[1:0])
         2'd1: lb = rd_data[15:8];
         2'd2: lb = rd_data[23:16];
         2'd3: lb = rd_data[31:24];
         default: lb = rd_data[7:0];
      endcase
      lh  = ea[1] ? rd_data[31:16] : rd_data[15:0];
      ldv = rd_data;
      case (f3)
         3'b000: ldv = {{24{lb[7]}}, lb};
         3'b001: ldv = {{16{lh[15]}}, lh};
         3'b100: ldv = {24'd0, lb};
         3'b101: ldv = {16'd0, lh};
         default: ldv = rd_data;
      endcase
   end

   // Bus outputs are decoded from state and forced low while rst is high
   always_comb begin
      state_n = state;
      pc_n    = pc;
      we      = 1'b0;
      wb      = 32'd0;
      rd_en   = 1'b0;
      rd_addr = 16'd0;
      wr_en   = 1'b0;
      wr_addr = 16'd0;
      wr_data = 32'd0;
      if (!rst) begin
         case (state)
            FETCH: begin
               rd_en   = 1'b1;
               rd_addr = pc[15:0];
               state_n = FWAIT;
            end
            FWAIT: begin
               if (rd_valid) state_n = EXEC;
            end
            EXEC: begin
               state_n = FETCH;
               pc_n    = pc + 32'd4;
               case (opc)
                  OP_LUI: begin
                     we = 1'b1;
                     wb = imm_u;
                  end
                  OP_AUIPC: begin
                     we = 1'b1;
                     wb = pc + imm_u;
                  end
                  OP_JAL: begin
                     we   = 1'b1;
                     wb   = pc + 32'd4;
                     pc_n = (pc + imm_j) & ~32'd3;
                  end
                  OP_JALR: begin
                     we   = 1'b1;
                     wb   = pc + 32'd4;
                     pc_n = (rs1 + imm_i) & ~32'd3;
                  end
                  OP_BR: begin
                     if (take) pc_n = (pc + imm_b) & ~32'd3;
                  end
                  OP_LD: begin
                     state_n = LOAD;
                     pc_n    = pc;
                  end
                  OP_ST: begin
                     state_n = STORE;
                     pc_n    = pc;
                  end
                  OP_IMM, OP_REG: begin
                     we = 1'b1;
                     wb = alu;
                  end
                  default: ;
               endcase
            end
            LOAD: begin
               rd_en   = 1'b1;
               rd_addr = ea_w;
               state_n = LWAIT;
            end
            LWAIT: begin
               if (rd_valid) begin
                  we      = 1'b1;
                  wb      = ldv;
                  pc_n    = pc + 32'd4;
                  state_n = FETCH;
               end
            end
            STORE: begin
               wr_en   = 1'b1;
               wr_addr = ea_w;
               wr_data = rs2;
               pc_n    = pc + 32'd4;
               state_n = FETCH;
            end
            default: state_n = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         pc    <= RESET_PC;
         ir    <= 32'd0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         if (state == FWAIT && rd_valid) ir <= rd_data;
         if (we && rd_i != 5'd0) regs[rd_i] <= wb;
      end
   end

`ifdef CPU_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst && state == EXEC)
         $display("trace pc=%h ir=%h x%0d=%h", pc, ir, rd_i, wb);
   end
`else
`endif

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs against an ISA-level reference model of cpu.
// The model predicts every bus strobe (kind, cycle, address, data).
module tb_cpu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en, wr_en, rd_valid;
   logic [15:0] rd_addr, wr_addr;
   logic [31:0] rd_data, wr_data;

   cpu dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   logic [31:0] mem   [1024];
   logic [31:0] m_mem [1024];
   logic [31:0] m_x   [32];
   logic [31:0] m_pc;
   logic [31:0] led;
   logic [15:0] stall_addr = 16'hffff;

   typedef struct {
      int          kind;
      logic [15:0] addr;
      logic [31:0] data;
      int          at;
   } ev_t;

   ev_t         eq[$];
   logic [31:0] fa_q[$], fc_q[$], la_q[$], wa_q[$], wd_q[$], wc_q[$];
   int          cyc = 0;

   function automatic logic [31:0] qa(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hxxxxxxxx;
   endfunction

   // instruction encoders
   function automatic logic [31:0] e_i(input int op, rd, f3, rs1, imm);
      logic [31:0] o = op, d = rd, f = f3, s = rs1, m = imm;
      return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
   endfunction
   function automatic logic [31:0] e_s(input int f3, rs1, rs2, imm);
      logic [31:0] f = f3, s = rs1, t = rs2, m = imm;
      return {m[11:5], t[4:0], s[4:0], f[2:0], m[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] e_b(input int f3, rs1, rs2, imm);
      logic [31:0] f = f3, s = rs1, t = rs2, m = imm;
      return {m[12], m[10:5], t[4:0], s[4:0], f[2:0], m[4:1], m[11], 7'h63};
   endfunction
   function automatic logic [31:0] e_u(input int op, rd, imm);
      logic [31:0] o = op, d = rd, m = imm;
      return {m[19:0], d[4:0], o[6:0]};
   endfunction
   function automatic logic [31:0] e_j(input int rd, imm);
      logic [31:0] d = rd, m = imm;
      return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6f};
   endfunction
   function automatic logic [31:0] e_r(input int f7, f3, rd, rs1, rs2);
      logic [31:0] g = f7, f = f3, d = rd, s = rs1, t = rs2;
      return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
   endfunction
   function automatic logic [31:0] addi(input int rd, rs1, imm);
      return e_i(19, rd, 0, rs1, imm);
   endfunction
   function automatic logic [31:0] sw(input int rs1, rs2, imm);
      return e_s(2, rs1, rs2, imm);
   endfunction

   // reference ISA semantics
   function automatic logic [31:0] m_alu(input int f3, input logic [31:0] a,
                                         input logic [31:0] b, input bit alt);
      logic signed [31:0] sv;
      sv = $signed(a) >>> b[4:0];
      case (f3)
         0: return alt ? a - b : a + b;
         1: return a << b[4:0];
         2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3: return (a < b) ? 32'd1 : 32'd0;
         4: return a ^ b;
         5: return alt ? sv : a >> b[4:0];
         6: return a | b;
         default: return a & b;
      endcase
   endfunction

   task automatic model_step(input int t);
      logic [31:0] ins, r1, r2, ii, is_, ib, ij, iu, res, nxt, ea, w, sh;
      logic [6:0]  op;
      int          f3, rd, s, nat;
      bit          wr, tk;
      ins = m_mem[m_pc[11:2]];
      s   = (m_pc[15:0] == stall_addr) ? 10 : 0;
      op  = ins[6:0];
      rd  = int'(ins[11:7]);
      f3  = int'(ins[14:12]);
      r1  = m_x[ins[19:15]];
      r2  = m_x[ins[24:20]];
      ii  = {{20{ins[31]}}, ins[31:20]};
      is_ = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      iu  = {ins[31:12], 12'd0};
      nxt = m_pc + 4;
      nat = t + 3 + s;
      res = 0;
      wr  = 0;
      case (op)
         7'h37: begin res = iu; wr = 1; end
         7'h17: begin res = m_pc + iu; wr = 1; end
         7'h6f: begin res = m_pc + 4; wr = 1; nxt = (m_pc + ij) & ~32'd3; end
         7'h67: begin res = m_pc + 4; wr = 1; nxt = (r1 + ii) & ~32'd3; end
         7'h63: begin
            case (f3)
               0: tk = r1 == r2;
               1: tk = r1 != r2;
               4: tk = $signed(r1) < $signed(r2);
               5: tk = $signed(r1) >= $signed(r2);
               6: tk = r1 < r2;
               7: tk = r1 >= r2;
               default: tk = 0;
            endcase
            if (tk) nxt = (m_pc + ib) & ~32'd3;
         end
         7'h13: begin res = m_alu(f3, r1, ii, ins[30] && f3 == 5); wr = 1; end
         7'h33: begin res = m_alu(f3, r1, r2, ins[30]); wr = 1; end
         7'h03: begin
            ea = r1 + ii;
            w  = m_mem[ea[11:2]];
            sh = w >> (8 * int'(ea[1:0]));
            case (f3)
               0: res = {{24{sh[7]}}, sh[7:0]};
               1: res = ea[1] ? {{16{w[31]}}, w[31:16]} : {{16{w[15]}}, w[15:0]};
               4: res = {24'd0, sh[7:0]};
               5: res = ea[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
               default: res = w;
            endcase
            wr = 1;
            eq.push_back('{1, {ea[15:2], 2'b00}, 32'd0, t + 3 + s});
            nat = t + 5 + s;
         end
         7'h23: begin
            ea = r1 + is_;
            if (ea < 32'h1000) m_mem[ea[11:2]] = r2;
            eq.push_back('{2, {ea[15:2], 2'b00}, r2, t + 3 + s});
            nat = t + 4 + s;
         end
         default: ;
      endcase
      if (wr && rd != 0) m_x[rd] = res;
      m_pc = nxt;
      eq.push_back('{0, nxt[15:0], 32'd0, nat});
   endtask

   // memory responder: one-cycle read latency, optional fetch stall
   initial begin
      rd_valid = 1'b0;
      rd_data  = 32'd0;
      forever begin
         logic [15:0] a;
         bit          req;
         @(negedge clk);
         if (wr_en && !rst) begin
            if (wr_addr < 16'h1000) mem[wr_addr[11:2]] = wr_data;
            else if (wr_addr == 16'h1000) led = wr_data;
         end
         req = rd_en && !rst;
         a   = rd_addr;
         if (req) begin
            @(posedge clk);
            #1;
            if (a == stall_addr) repeat (10) begin
               @(posedge clk);
               #1;
            end
            rd_valid = 1'b1;
            rd_data  = mem[a[11:2]];
            @(posedge clk);
            #1;
            rd_valid = 1'b0;
         end
      end
   end

   // per-cycle compare against the model's predicted strobes
   initial begin
      forever begin
         ev_t e;
         @(negedge clk);
         if (rst) begin
            cyc = 0;
            chk("rst_en", {30'd0, rd_en, wr_en}, 32'd0);
            chk("rst_addr", {rd_addr, wr_addr}, 32'd0);
            chk("rst_wdata", wr_data, 32'd0);
         end else begin
            chk("rd_wr_excl", {31'd0, rd_en && wr_en}, 32'd0);
            if (rd_en || wr_en) begin
               if (eq.size() == 0) begin
                  chk("strobe_unexpected", {31'd0, wr_en}, 32'hffffffff);
               end else begin
                  e = eq.pop_front();
                  chk("ev_kind", wr_en ? 2 : 1, (e.kind == 2) ? 2 : 1);
                  chk("ev_cycle", cyc, e.at);
                  if (wr_en) begin
                     chk("wr_addr", {16'd0, wr_addr}, {16'd0, e.addr});
                     chk("wr_data", wr_data, e.data);
                     wa_q.push_back({16'd0, wr_addr});
                     wd_q.push_back(wr_data);
                     wc_q.push_back(cyc);
                  end else begin
                     chk("rd_addr", {16'd0, rd_addr}, {16'd0, e.addr});
                     if (e.kind == 0) begin
                        fa_q.push_back({16'd0, rd_addr});
                        fc_q.push_back(cyc);
                     end else begin
                        la_q.push_back({16'd0, rd_addr});
                     end
                  end
                  if (e.kind == 0) model_step(cyc);
               end
            end else begin
               chk("idle_addr", {rd_addr, wr_addr}, 32'd0);
               chk("idle_wdata", wr_data, 32'd0);
               if (eq.size() > 0)
                  chk("strobe_late", {31'd0, eq[0].at <= cyc}, 32'd0);
            end
            cyc++;
         end
      end
   end

   task automatic begin_test(input logic [15:0] st);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         mem[i]   = 32'd0;
         m_mem[i] = 32'd0;
      end
      for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
      m_pc       = 32'd0;
      led        = 32'd0;
      stall_addr = st;
      eq.delete();
      fa_q.delete(); fc_q.delete(); la_q.delete();
      wa_q.delete(); wd_q.delete(); wc_q.delete();
   endtask

   task automatic put(input int a, input logic [31:0] w);
      mem[a / 4]   = w;
      m_mem[a / 4] = w;
   endtask

   task automatic run(input int n);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      eq.push_back('{0, 16'h0000, 32'd0, 0});
      repeat (n) @(posedge clk);
   endtask

   initial begin
      // T0: all-zero memory decodes as NOPs
      begin_test(16'hffff);
      run(12);
      chk("t0_fetch0_addr", qa(fa_q, 0), 32'h0);
      chk("t0_fetch0_cyc", qa(fc_q, 0), 32'd0);
      chk("t0_fetch1_addr", qa(fa_q, 1), 32'h4);
      chk("t0_fetch1_cyc", qa(fc_q, 1), 32'd3);

      // T1: addi chain and store
      begin_test(16'hffff);
      put(0, addi(1, 0, 5));
      put(4, addi(2, 1, -3));
      put(8, sw(0, 2, 32'h100));
      put(12, e_j(0, 0));
      run(25);
      chk("t1_wa", qa(wa_q, 0), 32'h100);
      chk("t1_wd", qa(wd_q, 0), 32'h2);
      chk("t1_wcyc", qa(wc_q, 0), 32'd9);
      chk("t1_model_x2", m_x[2], 32'h2);

      // T2: LUI base and store to the LED register
      begin_test(16'hffff);
      put(0, e_u(32'h37, 1, 1));
      put(4, addi(2, 0, 4));
      put(8, sw(1, 2, 0));
      put(12, e_j(0, 0));
      run(25);
      chk("t2_wa", qa(wa_q, 0), 32'h1000);
      chk("t2_wd", qa(wd_q, 0), 32'h4);
      chk("t2_led", led, 32'h4);

      // T3: loads of every lane width, with a 10-cycle fetch stall at 0x04
      begin_test(16'h0004);
      put(32'h00, e_i(3, 1, 2, 0, 32'h10));
      put(32'h04, e_i(3, 2, 0, 0, 32'h10));
      put(32'h08, e_i(3, 3, 4, 0, 32'h13));
      put(32'h0c, e_j(0, 8));
      put(32'h10, 32'hdeadbeef);
      put(32'h14, e_i(3, 4, 1, 0, 32'h12));
      put(32'h18, sw(0, 1, 32'h200));
      put(32'h1c, sw(0, 2, 32'h204));
      put(32'h20, sw(0, 3, 32'h208));
      put(32'h24, sw(0, 4, 32'h20c));
      put(32'h28, e_j(0, 0));
      run(110);
      chk("t3_lw_addr", qa(la_q, 0), 32'h10);
      chk("t3_lbu_addr", qa(la_q, 2), 32'h10);
      chk("t3_stall_fetch_cyc", qa(fc_q, 2), 32'd20);
      chk("t3_lw", qa(wd_q, 0), 32'hdeadbeef);
      chk("t3_lb", qa(wd_q, 1), 32'hffffffef);
      chk("t3_lbu", qa(wd_q, 2), 32'h000000de);
      chk("t3_lh", qa(wd_q, 3), 32'hffffdead);
      chk("t3_model_x4", m_x[4], 32'hffffdead);

      // T4: jumps, countdown loop, x0 writes, shifts, sub, auipc, slt
      begin_test(16'hffff);
      put(32'h00, e_j(0, 32'h20));
      put(32'h20, e_j(1, 8));
      put(32'h24, addi(5, 0, 1));
      put(32'h28, sw(0, 1, 32'h300));
      put(32'h2c, addi(6, 0, 3));
      put(32'h30, addi(7, 7, 1));
      put(32'h34, addi(6, 6, -1));
      put(32'h38, e_b(1, 6, 0, -8));
      put(32'h3c, sw(0, 7, 32'h304));
      put(32'h40, addi(0, 0, 7));
      put(32'h44, sw(0, 0, 32'h308));
      put(32'h48, sw(0, 5, 32'h30c));
      put(32'h4c, e_i(32'h67, 1, 0, 1, 32'h30));
      put(32'h50, addi(5, 0, 9));
      put(32'h54, sw(0, 1, 32'h310));
      put(32'h58, addi(9, 0, -16));
      put(32'h5c, e_i(19, 10, 5, 9, 32'h402));
      put(32'h60, e_i(19, 11, 5, 9, 28));
      put(32'h64, e_r(32'h20, 0, 12, 0, 9));
      put(32'h68, sw(0, 10, 32'h314));
      put(32'h6c, sw(0, 11, 32'h318));
      put(32'h70, sw(0, 12, 32'h31c));
      put(32'h74, e_u(32'h17, 13, 1));
      put(32'h78, e_r(0, 2, 14, 9, 0));
      put(32'h7c, sw(0, 13, 32'h320));
      put(32'h80, sw(0, 14, 32'h324));
      put(32'h84, e_j(0, 0));
      run(140);
      chk("t4_fetch_jal", qa(fa_q, 1), 32'h20);
      chk("t4_fetch_tgt", qa(fa_q, 2), 32'h28);
      chk("t4_link", qa(wd_q, 0), 32'h24);
      chk("t4_loop_cnt", qa(wd_q, 1), 32'h3);
      chk("t4_x0", qa(wd_q, 2), 32'h0);
      chk("t4_skipped", qa(wd_q, 3), 32'h0);
      chk("t4_jalr_link", qa(wd_q, 4), 32'h50);
      chk("t4_srai", qa(wd_q, 5), 32'hfffffffc);
      chk("t4_srli", qa(wd_q, 6), 32'h0000000f);
      chk("t4_sub", qa(wd_q, 7), 32'h10);
      chk("t4_auipc", qa(wd_q, 8), 32'h1074);
      chk("t4_slt", qa(wd_q, 9), 32'h1);
      chk("t4_model_x7", m_x[7], 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
